// File: rtl/minmax_pkg.sv
// Shared types and width helpers for the min/max frame reducer.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // A one-entry index still needs a bit, so clamp the width at 1.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/minmax_frame_reducer_if.sv
// Sample-in / result-out handshake bundle for the min/max frame reducer.
interface minmax_frame_reducer_if #(
  parameter int DATA      = 8,
  parameter int FRAME_LEN = 16
);
  import minmax_pkg::*;

  localparam int IDXW = idx_width(FRAME_LEN);
  localparam int CNTW = cnt_width(FRAME_LEN);

  logic            in_valid;
  logic            in_ready;
  logic [DATA-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DATA-1:0] out_min;
  logic [DATA-1:0] out_max;
  logic [IDXW-1:0] out_min_idx;
  logic [IDXW-1:0] out_max_idx;
  logic [CNTW-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_min_idx, out_max_idx, out_count
  );

endinterface

// File: rtl/minmax_update.sv
// Combinational running min/max step; strict compares keep the earliest index on ties.
module minmax_update
  import minmax_pkg::*;
#(
  parameter int DATA = 8,
  parameter int IDXW = 4
) (
  input  logic [DATA-1:0] cur_min,
  input  logic [DATA-1:0] cur_max,
  input  logic [IDXW-1:0] cur_min_idx,
  input  logic [IDXW-1:0] cur_max_idx,
  input  logic [DATA-1:0] sample,
  input  logic [IDXW-1:0] sample_idx,
  output logic [DATA-1:0] new_min,
  output logic [DATA-1:0] new_max,
  output logic [IDXW-1:0] new_min_idx,
  output logic [IDXW-1:0] new_max_idx
);

  always_comb begin
    new_min     = cur_min;
    new_max     = cur_max;
    new_min_idx = cur_min_idx;
    new_max_idx = cur_max_idx;
    if (sample < cur_min) begin
      new_min     = sample;
      new_min_idx = sample_idx;
    end
    if (sample > cur_max) begin
      new_max     = sample;
      new_max_idx = sample_idx;
    end
  end

endmodule

// File: rtl/minmax_frame_reducer.sv
// Streams a frame of unsigned samples in and presents its min, max, their indices and the count.
module minmax_frame_reducer
  import minmax_pkg::*;
#(
  parameter int DATA      = 8,
  parameter int FRAME_LEN = 16,
  localparam int IDXW     = idx_width(FRAME_LEN),
  localparam int CNTW     = cnt_width(FRAME_LEN)
) (
  input logic                  clk,
  input logic                  rst,
  minmax_frame_reducer_if.slave bus
);

  state_t          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [DATA-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [IDXW-1:0] run_min_idx_q, run_min_idx_d, run_max_idx_q, run_max_idx_d;
  logic [DATA-1:0] res_min_q, res_min_d, res_max_q, res_max_d;
  logic [IDXW-1:0] res_min_idx_q, res_min_idx_d, res_max_idx_q, res_max_idx_d;
  logic [CNTW-1:0] res_count_q, res_count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            in_fire, out_fire, first, frame_end;
  logic [DATA-1:0] base_min, base_max, upd_min, upd_max;
  logic [IDXW-1:0] base_min_idx, base_max_idx, sample_idx, upd_min_idx, upd_max_idx;
  logic [CNTW-1:0] next_count;

  // The first sample seeds the comparison with itself, so it always lands at index 0.
  assign in_fire      = bus.in_valid && in_ready_q;
  assign out_fire     = out_valid_q && bus.out_ready;
  assign first        = (state_q == IDLE);
  assign base_min     = first ? bus.in_data : run_min_q;
  assign base_max     = first ? bus.in_data : run_max_q;
  assign base_min_idx = first ? '0 : run_min_idx_q;
  assign base_max_idx = first ? '0 : run_max_idx_q;
  assign sample_idx   = first ? '0 : count_q[IDXW-1:0];
  assign next_count   = first ? CNTW'(1) : count_q + CNTW'(1);
  assign frame_end    = in_fire && (bus.in_last || (next_count == CNTW'(FRAME_LEN)));

  minmax_update #(
    .DATA (DATA),
    .IDXW (IDXW)
  ) u_update (
    .cur_min     (base_min),
    .cur_max     (base_max),
    .cur_min_idx (base_min_idx),
    .cur_max_idx (base_max_idx),
    .sample      (bus.in_data),
    .sample_idx  (sample_idx),
    .new_min     (upd_min),
    .new_max     (upd_max),
    .new_min_idx (upd_min_idx),
    .new_max_idx (upd_max_idx)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    run_min_d     = run_min_q;
    run_max_d     = run_max_q;
    run_min_idx_d = run_min_idx_q;
    run_max_idx_d = run_max_idx_q;
    res_min_d     = res_min_q;
    res_max_d     = res_max_q;
    res_min_idx_d = res_min_idx_q;
    res_max_idx_d = res_max_idx_q;
    res_count_d   = res_count_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          state_d       = ACCUM;
          count_d       = next_count;
          run_min_d     = upd_min;
          run_max_d     = upd_max;
          run_min_idx_d = upd_min_idx;
          run_max_idx_d = upd_max_idx;
          if (frame_end) begin
            state_d       = HOLD;
            count_d       = '0;
            in_ready_d    = 1'b0;
            out_valid_d   = 1'b1;
            res_min_d     = upd_min;
            res_max_d     = upd_max;
            res_min_idx_d = upd_min_idx;
            res_max_idx_d = upd_max_idx;
            res_count_d   = next_count;
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      run_min_q     <= '0;
      run_max_q     <= '0;
      run_min_idx_q <= '0;
      run_max_idx_q <= '0;
      res_min_q     <= '0;
      res_max_q     <= '0;
      res_min_idx_q <= '0;
      res_max_idx_q <= '0;
      res_count_q   <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      run_min_q     <= run_min_d;
      run_max_q     <= run_max_d;
      run_min_idx_q <= run_min_idx_d;
      run_max_idx_q <= run_max_idx_d;
      res_min_q     <= res_min_d;
      res_max_q     <= res_max_d;
      res_min_idx_q <= res_min_idx_d;
      res_max_idx_q <= res_max_idx_d;
      res_count_q   <= res_count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_min     = res_min_q;
  assign bus.out_max     = res_max_q;
  assign bus.out_min_idx = res_min_idx_q;
  assign bus.out_max_idx = res_max_idx_q;
  assign bus.out_count   = res_count_q;

endmodule

// File: doc/minmax_frame_reducer.md
# minmax_frame_reducer

Streaming consumer that reads a frame of unsigned samples over a valid/ready interface. It reduces the frame to its minimum, its maximum and the index of each. It complements the team's two-operand registered min/max comparator: that block produces ordered pairs, and this block consumes a sample stream and summarises it. It sits between a sample producer (ADC capture, sensor FIFO) and statistics/threshold logic.

## Interface
- DATA, 8, sample width in bits (unsigned)
- FRAME_LEN, 16, maximum samples per frame; legal range is 2 or more
- IDXW, $clog2(FRAME_LEN), index width (derived; do not override)
- CNTW, $clog2(FRAME_LEN+1), count width (derived; do not override)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer has a sample
- in_ready  out  1  block accepts a sample (registered)
- in_data  in  DATA  sample
- in_last  in  1  marks the final sample of a short frame; qualified by in_valid
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_min  out  DATA  frame minimum
- out_max  out  DATA  frame maximum
- out_min_idx  out  IDXW  position of the minimum within the frame, 0-based
- out_max_idx  out  IDXW  position of the maximum within the frame, 0-based
- out_count  out  CNTW  number of samples in the frame

## Operation
- Input transfer happens when in_valid and in_ready are both high on a rising clk edge.
- Output transfer happens when out_valid and out_ready are both high.
- States:
  - IDLE: awaiting the first sample. On input transfer: min = max = in_data, both indices 0, count 1, go to ACCUM.
  - ACCUM: on each input transfer, update the running values.
  - HOLD: result presented on the outputs. in_ready is 0.
- Transition from IDLE or ACCUM to HOLD occurs on the transfer that carries in_last=1, or on the transfer that makes count reach FRAME_LEN, whichever comes first.
- If in_last=1 arrives on the first sample, the result is a 1-sample frame (count 1, min = max = sample, both indices 0).
- Update rule: min is replaced only if in_data < min, and max only if in_data > max. Comparison is unsigned and strict, so on ties both indices keep the earliest occurrence.
- On the transfer that ends a frame, the final sample takes part in the update before the result is latched.
- HOLD to IDLE occurs on output transfer. Outputs keep their values until the next frame ends.
- in_last asserted while in_valid is low is ignored.
- Samples present while in HOLD are not accepted, because in_ready is 0. The producer must hold them.
- Reset mid-frame discards all partial results, with no output produced.

## Timing
- Reset values:
  - in_ready = 0
  - out_valid = 0
  - out_min, out_max, out_min_idx, out_max_idx and out_count all = 0
  - state = IDLE
- in_ready rises on the first clk edge after rst deasserts.
- Throughput: 1 sample per cycle while in IDLE or ACCUM.
- Latency: out_valid is asserted on the edge that accepts the final sample. It is visible in the next cycle, together with all result fields. On that same edge, in_ready falls.
- out_valid stays high and the result fields stay stable until out_ready is high.
- in_ready returns to 1 on the edge of the output transfer, so the next frame's first sample can transfer in the following cycle. The minimum gap between frames is therefore 1 cycle.
- out_ready held high continuously gives 1 idle input cycle per frame.
- Indices never wrap: count at most FRAME_LEN, index at most FRAME_LEN-1.

## Structure
- Package minmax_pkg contains:
  - state enum {IDLE, ACCUM, HOLD}
  - width helper functions for IDXW and CNTW
- Sub-module minmax_update (combinational): takes the current min/max/indices, the new sample and its index, and returns the updated min/max/indices under the strict tie rule.
- The top level holds the FSM, counter, registers and handshake.

## Test plan
- FRAME_LEN=4, no stalls, samples 5,2,9,2 → min 2 idx 1, max 9 idx 2, count 4. out_valid appears 1 cycle after the 4th transfer.
- Samples 7,3,in_last on 8 (FRAME_LEN=16) → min 3 idx 1, max 8 idx 2, count 3. in_ready is 0 until out_ready.
- Single sample 0xAA with in_last=1 → min = max = 0xAA, both indices 0, count 1.
- All equal 4,4,4,4 → min = max = 4, both indices 0. Then 0xFF,0x00 in the next frame → max 0xFF idx 0, min 0x00 idx 1 (unsigned check).
- Hold out_ready low for 5 cycles with in_valid high → no input transfers, result fields stable. Release → in_ready is 1 the next cycle, and the new frame's first sample is at idx 0.
- Assert rst after 2 samples of a frame → all outputs 0 asynchronously. After release, frame 1,6 with in_last → min 1 idx 0, max 6 idx 1, count 2 (stale data discarded).
